// File: rtl/seg_time_disp_pkg.sv
// Shared constants, types and the 7-segment code table for the HH MM SS display.
// Segment codes are active-low, bit 7 is the decimal point (off = 1).
package seg_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [5:0]  SEL_OFF    = 6'h3F;

  typedef logic [2:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_DIGITS - 1);

  function automatic logic [7:0] seg_code(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_time_disp_bin2bcd.sv
// Combinational binary-to-BCD split of a 6-bit value (0..63) into tens and ones digits.
module bin2bcd_6b (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [5:0] tens_full;
  logic [5:0] ones_full;

  assign tens_full = bin_i / 6'd10;
  assign ones_full = bin_i % 6'd10;
  assign tens_o    = tens_full[3:0];
  assign ones_o    = ones_full[3:0];

endmodule

// File: rtl/seg_time_disp.sv
// Multiplexed 6-digit HH MM SS driver with a per-frame input snapshot; outputs registered.
// Optional blinking separator dots on idx1/idx3 when DP_BLINK_EN is defined.
module seg_time_disp
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       frame
);

  localparam int SCAN_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGIT_CYCLES - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  idx_t              idx_q, idx_d;
  logic [5:0]        snap_h_q, snap_h_d;
  logic [5:0]        snap_m_q, snap_m_d;
  logic [5:0]        snap_s_q, snap_s_d;
  logic [7:0]        seg_q, seg_d;
  logic [5:0]        sel_q, sel_d;
  logic              frame_q, frame_d;

  logic              scan_last;
  logic              frame_load;
  logic [5:0]        field;
  logic [3:0]        bcd_tens;
  logic [3:0]        bcd_ones;
  logic [3:0]        digit;
  logic [7:0]        code;
  logic              dp_bit;

  bin2bcd_6b u_bin2bcd (
    .bin_i  (field),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

`ifdef DP_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               dp_on_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      dp_on_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      dp_on_q     <= ~dp_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  // Separator dots sit after the hour and minute ones digits.
  assign dp_bit = (idx_q == idx_t'(1) || idx_q == idx_t'(3)) ? ~dp_on_q : 1'b1;
`else
  assign dp_bit = 1'b1;
`endif

  always_comb begin
    scan_last  = (scan_cnt_q == SCAN_LAST);
    frame_load = scan_last && (idx_q == LAST_IDX);

    scan_cnt_d = scan_last ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_last) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
    end

    snap_h_d = frame_load ? hour   : snap_h_q;
    snap_m_d = frame_load ? minute : snap_m_q;
    snap_s_d = frame_load ? second : snap_s_q;

    case (idx_q)
      idx_t'(0), idx_t'(1): field = snap_h_q;
      idx_t'(2), idx_t'(3): field = snap_m_q;
      default:              field = snap_s_q;
    endcase

    digit = idx_q[0] ? bcd_ones : bcd_tens;
    code  = seg_code(digit);

    // First cycle of every digit is blanked so the previous digit does not ghost.
    sel_d   = (scan_cnt_q == '0) ? SEL_OFF : ~(6'b1 << idx_q);
    seg_d   = {dp_bit, code[6:0]};
    frame_d = frame_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      snap_h_q   <= '0;
      snap_m_q   <= '0;
      snap_s_q   <= '0;
      sel_q      <= SEL_OFF;
      seg_q      <= SEG_BLANK;
      frame_q    <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      snap_h_q   <= snap_h_d;
      snap_m_q   <= snap_m_d;
      snap_s_q   <= snap_s_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign sel   = sel_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_time_disp.sv
// Self-checking bench for seg_time_disp with DIGIT_CYCLES=4, BLINK_CYCLES=8.
// Expected outputs come from a cycle-count reference model of the display schedule.
module tb_seg_time_disp;

  localparam int DC    = 4;
  localparam int BC    = 8;
  localparam int FRAME = DC * 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hour, minute, second;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       frame;

  int errors = 0;
  int checks = 0;

  seg_time_disp #(.DIGIT_CYCLES(DC), .BLINK_CYCLES(BC)) dut (
    .clk    (clk),
    .rst    (rst),
    .hour   (hour),
    .minute (minute),
    .second (second),
    .seg    (seg),
    .sel    (sel),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         edges_q;
  logic [5:0] m_h, m_m, m_s;
  logic [5:0] exp_sel;
  logic [7:0] exp_seg;
  logic       exp_frame;

  logic [7:0] map_seg [6] = '{8'hA4, 8'hB0, 8'h92, 8'h90, 8'h92, 8'hC0};
  logic [5:0] map_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  function automatic logic [7:0] code_of(input int d);
    logic [7:0] c;
    case (d)
      0: c = 8'hC0; 1: c = 8'hF9; 2: c = 8'hA4; 3: c = 8'hB0; 4: c = 8'h99;
      5: c = 8'h92; 6: c = 8'h82; 7: c = 8'hF8; 8: c = 8'h80; 9: c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // t = cycles since reset release, i.e. the state just before the current edge.
  function automatic logic [13:0] model_out(input int t, input logic [5:0] h,
                                            input logic [5:0] m, input logic [5:0] s);
    int         sc, ix, v, d;
    logic [7:0] sg;
    logic [5:0] sl;
    sc = t % DC;
    ix = (t / DC) % 6;
    v  = (ix < 2) ? int'(h) : (ix < 4) ? int'(m) : int'(s);
    d  = (ix % 2 == 1) ? v % 10 : v / 10;
    sg = code_of(d);
`ifdef DP_BLINK_EN
    if (ix == 1 || ix == 3) sg[7] = ((t / BC) % 2 == 0);
`endif
    sl = (sc == 0) ? 6'h3F : ~(6'd1 << ix);
    return {sl, sg};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      edges_q   <= 0;
      m_h       <= '0;
      m_m       <= '0;
      m_s       <= '0;
      exp_sel   <= 6'h3F;
      exp_seg   <= 8'hFF;
      exp_frame <= 1'b0;
    end else begin
      {exp_sel, exp_seg} <= model_out(edges_q, m_h, m_m, m_s);
      edges_q            <= edges_q + 1;
      exp_frame          <= ((edges_q + 1) % FRAME == 0);
      if ((edges_q + 1) % FRAME == 0) begin
        m_h <= hour;
        m_m <= minute;
        m_s <= second;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF || frame !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got sel=%h seg=%h frame=%b, want sel=3f seg=ff frame=0",
                 i, sel, seg, frame);
      end
    end
  endtask

  task automatic test_digit_map();
    int t, ix, sc, fr;
    hour = 6'd23; minute = 6'd59; second = 6'd50;
    rst  = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      t = edges_q - 1; ix = (t / DC) % 6; sc = t % DC; fr = t / FRAME;
      checks++;
      if (sel !== exp_sel || seg !== exp_seg || frame !== exp_frame) begin
        errors++;
        $display("FAIL digit_map model t=%0d: got sel=%h seg=%h frame=%b, want sel=%h seg=%h frame=%b",
                 t, sel, seg, frame, exp_sel, exp_seg, exp_frame);
      end
      checks++;
      if (fr == 0 && seg[6:0] !== 7'h40) begin
        errors++;
        $display("FAIL first_frame_zero t=%0d: got seg=%h, want C0", t, seg);
      end else if (fr == 1 && (seg[6:0] !== map_seg[ix][6:0] ||
                               sel !== ((sc == 0) ? 6'h3F : map_sel[ix]))) begin
        errors++;
        $display("FAIL digit_map idx%0d sc%0d: got sel=%h seg=%h, want sel=%h seg=%h",
                 ix, sc, sel, seg, (sc == 0) ? 6'h3F : map_sel[ix], map_seg[ix]);
      end
    end
  endtask

  task automatic test_snapshot();
    int start, rel, ix, pulses;
    int waited = 0;
    while (edges_q % FRAME != 0 && waited < FRAME + 2) begin
      @(negedge clk); waited++;
    end
    start  = edges_q;
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 10) second = 6'd51;
      @(negedge clk);
      rel = edges_q - 1 - start;
      ix  = (rel / DC) % 6;
      if (frame === 1'b1) pulses++;
      checks++;
      if (sel !== exp_sel || seg !== exp_seg || frame !== exp_frame) begin
        errors++;
        $display("FAIL snapshot model rel=%0d: got sel=%h seg=%h frame=%b, want sel=%h seg=%h frame=%b",
                 rel, sel, seg, frame, exp_sel, exp_seg, exp_frame);
      end
      if (ix == 5) begin
        checks++;
        if (seg !== ((rel < FRAME) ? 8'hC0 : 8'hF9)) begin
          errors++;
          $display("FAIL snapshot idx5 rel=%0d: got seg=%h, want %h",
                   rel, seg, (rel < FRAME) ? 8'hC0 : 8'hF9);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_rate: got %0d pulses in 48 cycles, want 2", pulses);
    end
  endtask

  task automatic test_no_clamp();
    int waited = 0;
    int seen = 0;
    int ix;
    hour = 6'd63;
    @(negedge clk);
    while (edges_q % FRAME != 0 && waited < FRAME + 2) begin
      @(negedge clk); waited++;
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      ix = ((edges_q - 1) / DC) % 6;
      if (ix < 2) begin
        seen++;
        checks++;
        if (seg[6:0] !== ((ix == 0) ? 7'h02 : 7'h30)) begin
          errors++;
          $display("FAIL no_clamp idx%0d: got seg=%h, want %h", ix, seg,
                   (ix == 0) ? 8'h82 : 8'hB0);
        end
      end
    end
    checks++;
    if (seen != 2 * DC) begin
      errors++;
      $display("FAIL no_clamp_cover: got %0d idx0/1 samples, want %0d", seen, 2 * DC);
    end
  endtask

  task automatic test_dp();
    int t, ix;
    logic want;
    for (int i = 0; i < 4 * BC * 2; i++) begin
      @(negedge clk);
      t  = edges_q - 1;
      ix = (t / DC) % 6;
`ifdef DP_BLINK_EN
      want = (ix == 1 || ix == 3) ? (((t / BC) % 2) == 0) : 1'b1;
`else
      want = 1'b1;
`endif
      checks++;
      if (seg[7] !== want) begin
        errors++;
        $display("FAIL dp t=%0d idx%0d: got seg7=%b, want %b", t, ix, seg[7], want);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int r = 0; r < 20; r++) begin
      hour   = 6'($urandom_range(0, 63));
      minute = 6'($urandom_range(0, 63));
      second = 6'($urandom_range(0, 63));
      hold   = int'($urandom_range(1, 40));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (sel !== exp_sel || seg !== exp_seg || frame !== exp_frame) begin
          errors++;
          $display("FAIL random r=%0d: got sel=%h seg=%h frame=%b, want sel=%h seg=%h frame=%b",
                   r, sel, seg, frame, exp_sel, exp_seg, exp_frame);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    hour = 6'd12; minute = 6'd34; second = 6'd56;
    while (edges_q % FRAME != 14 && waited < FRAME + 2) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (edges_q % FRAME != 14) begin
      errors++;
      $display("FAIL mid_reset_align: got phase %0d, want 14", edges_q % FRAME);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF || frame !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got sel=%h seg=%h frame=%b, want sel=3f seg=ff frame=0",
               sel, seg, frame);
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (seg[6:0] !== 7'h40 || sel !== exp_sel || frame !== exp_frame) begin
        errors++;
        $display("FAIL restart i=%0d: got sel=%h seg=%h frame=%b, want sel=%h seg=C0 frame=%b",
                 i, sel, seg, frame, exp_sel, exp_frame);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hour = '0; minute = '0; second = '0;
    test_reset();
    test_digit_map();
    test_snapshot();
    test_no_clamp();
    test_dp();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
